// File: rtl/memwb_pipe_reg.sv
// MEM->WB pipeline register with a valid/ready handshake, a one-entry skid buffer and flush.
// The write-back result is extracted from the load data and stored when the entry is captured.
module memwb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RFWEM,
  input  logic              MtoRFSelM,
  input  logic [1:0]        LdSizeM,
  input  logic              LdSignM,
  input  logic [OFF_W-1:0]  ByteOffM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] DMRD,
  input  logic [RA_W-1:0]   RFAM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RFWEW,
  output logic              MtoRFSelW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] DMOutW,
  output logic [RA_W-1:0]   RFAW,
  output logic [DATA_W-1:0] ResultW
);

  typedef struct packed {
    logic              rfwe;
    logic              sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] dm;
    logic [RA_W-1:0]   rfa;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t mEntry_q, mEntry_d;
  entry_t sEntry_q, sEntry_d;
  entry_t inEntry;
  logic   mValid_q, mValid_d;
  logic   sValid_q, sValid_d;

  logic [OFF_W+2:0]  byteShamt;
  logic [OFF_W+2:0]  halfShamt;
  logic [DATA_W-1:0] byteShift;
  logic [DATA_W-1:0] halfShift;
  logic [7:0]        byteLane;
  logic [15:0]       halfLane;
  logic [DATA_W-1:0] extracted;
  logic              inXfer;
  logic              mFree;

  // Half-word lanes are aligned: the low offset bit is dropped before scaling.
  always_comb begin
    byteShamt = {ByteOffM, 3'b000};
    halfShamt = {ByteOffM[OFF_W-1:1], 4'b0000};
    byteShift = DMRD >> byteShamt;
    halfShift = DMRD >> halfShamt;
    byteLane  = byteShift[7:0];
    halfLane  = halfShift[15:0];
    case (LdSizeM)
      2'b00:   extracted = {{(DATA_W-8){LdSignM & byteLane[7]}}, byteLane};
      2'b01:   extracted = {{(DATA_W-16){LdSignM & halfLane[15]}}, halfLane};
      default: extracted = DMRD;
    endcase
  end

  always_comb begin
    inEntry.rfwe   = RFWEM;
    inEntry.sel    = MtoRFSelM;
    inEntry.alu    = ALUOutM;
    inEntry.dm     = DMRD;
    inEntry.rfa    = RFAM;
    inEntry.result = MtoRFSelM ? extracted : ALUOutM;
  end

  assign in_ready = ~sValid_q;
  assign inXfer   = in_valid & ~sValid_q;
  assign mFree    = ~mValid_q | out_ready;

  always_comb begin
    mValid_d = mValid_q;
    sValid_d = sValid_q;
    mEntry_d = mEntry_q;
    sEntry_d = sEntry_q;
    if (flush) begin
      mValid_d = 1'b0;
      sValid_d = 1'b0;
    end else if (mFree) begin
      if (sValid_q) begin
        mEntry_d = sEntry_q;
        mValid_d = 1'b1;
        sValid_d = inXfer;
        if (inXfer) sEntry_d = inEntry;
      end else if (inXfer) begin
        mEntry_d = inEntry;
        mValid_d = 1'b1;
      end else begin
        mValid_d = 1'b0;
      end
    end else if (inXfer) begin
      // M is stalled: park the accepted entry in the skid slot, which closes in_ready.
      sEntry_d = inEntry;
      sValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid_q <= 1'b0;
      sValid_q <= 1'b0;
      mEntry_q <= '0;
      sEntry_q <= '0;
    end else begin
      mValid_q <= mValid_d;
      sValid_q <= sValid_d;
      mEntry_q <= mEntry_d;
      sEntry_q <= sEntry_d;
    end
  end

  assign out_valid = mValid_q;
  assign RFWEW     = mEntry_q.rfwe & mValid_q;
  assign MtoRFSelW = mEntry_q.sel;
  assign ALUOutW   = mEntry_q.alu;
  assign DMOutW    = mEntry_q.dm;
  assign RFAW      = mEntry_q.rfa;
  assign ResultW   = mEntry_q.result;

endmodule

// File: doc/memwb_pipe_reg.md
# memwb_pipe_reg

Parametrised MEM→WB pipeline register with valid/ready handshake, one-entry skid buffer, synchronous flush and write-back load extraction. It replaces the plain always-loading MEM/WB register between the data-memory stage and register-file write-back. It adds stall back-pressure, bubble/flush handling, and a selected, size- and sign-corrected write-back result.

## Interface
- DATA_W, 32, datapath width; must be 32 or 64.
- RA_W, 5, register-file address width.
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; not overridden).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  block can accept this cycle
- RFWEM  in  1  register-file write enable
- MtoRFSelM  in  1  1 = result from memory, 0 = from ALU
- LdSizeM  in  2  00 byte, 01 half, 10/11 full word
- LdSignM  in  1  1 = sign-extend sub-word load
- ByteOffM  in  OFF_W  byte address of load within the word
- ALUOutM  in  DATA_W  ALU result
- DMRD  in  DATA_W  raw data-memory read word
- RFAM  in  RA_W  destination register
- out_valid  out  1  WB entry valid
- out_ready  in  1  write-back consumes the entry
- RFWEW  out  1  RFWE of held entry AND out_valid
- MtoRFSelW  out  1  held select
- ALUOutW  out  DATA_W  held ALU result
- DMOutW  out  DATA_W  held raw memory word
- RFAW  out  RA_W  held destination
- ResultW  out  DATA_W  final write-back value (registered)

## Operation
- Storage: main register M (drives outputs) and skid register S, each with its own valid bit. The payload is {RFWE, MtoRFSel, ALUOut, DMRD, RFA, Result}.
- Load extraction happens at capture, combinationally on the inputs. The result is stored, so ResultW adds no output-path logic.
  - Byte: lane = DMRD[8*ByteOffM +: 8]. Zero- or sign-extended to DATA_W.
  - Half: lane = DMRD[16*ByteOffM[OFF_W-1:1] +: 16]. ByteOffM[0] is ignored. Zero- or sign-extended.
  - Word: DMRD unchanged. LdSignM and ByteOffM are ignored.
  - Result = MtoRFSelM ? extracted : ALUOutM.
- in_ready = !S.valid. It depends only on registered state.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Per-edge behaviour when flush=0:
  - M empty, or M consumed: M ← S if S is valid, otherwise M ← the input if an input transfer occurs, otherwise M becomes invalid.
  - When S moves into M and an input transfer occurs in the same cycle, the input goes to S.
  - M held and not consumed, with an input transfer: the input goes to S, which stalls upstream next cycle.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- Flush=1: at the edge, M.valid and S.valid go to 0. Any input offered that cycle is discarded, even if in_ready=1. Payload registers may keep stale data, but RFWEW must read 0.
- Flush has priority over all transfers.
- Reset: all valid bits, payloads and outputs are 0 immediately on rst rising, and in_ready=1. Transfers are ignored while rst=1. A reset mid-stall loses both entries.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N with out_valid=1, when M was empty or consumed.
- Throughput: 1 entry per cycle when out_ready is held high.
- Stall onset: if out_ready=0 and M is valid, one more input is absorbed into S. in_ready drops in the following cycle.
- Stall release: in the cycle out_ready returns to 1, S moves to M at the edge, and in_ready=1 in the next cycle.
- RFWEW, ResultW and the other outputs change only on clk edges or rst. There is no combinational path from inputs to outputs. out_ready affects only next-state.
- A simultaneous flush and out_ready=1 consumes nothing new; the current M value is visible that cycle only.

## Test plan
- Reset: assert rst mid-stream with M and S valid → out_valid=0, RFWEW=0, ResultW=0, in_ready=1 immediately, with no clock needed.
- Streaming: out_ready=1, ten back-to-back ALU ops (MtoRFSelM=0, RFAM=1..10) → each appears one cycle later, ResultW=ALUOutM, no bubbles.
- Load extraction: DMRD=0x8070_F0A5.
  - byte offset 0, signed → ResultW=0xFFFF_FFA5.
  - byte offset 1, unsigned → 0x0000_00F0.
  - half offset 2, signed → 0xFFFF_8070.
  - word → 0x8070_F0A5.
- Back-pressure: drop out_ready for 3 cycles with in_valid=1 → exactly one extra entry is absorbed, in_ready=0 for the remainder of the stall, and on release entries drain in order with none lost.
- Flush: with M and S both valid and in_valid=1, pulse flush → next cycle out_valid=0, RFWEW=0, in_ready=1, and the flushed-cycle input never appears.
- Parameter sweep: DATA_W=64, byte offset 7, signed, lane=0x80 → ResultW=0xFFFF_FFFF_FFFF_FF80.
